instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, SHALL be driven on if_instruction whenever no valid instruction is held.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stall_if_id  input  1  SHALL indicate that the IF/ID register is holding, so the held instruction is not consumed.
REQ-006 redirect_valid  input  1  SHALL indicate a branch/jump redirect request.
REQ-007 redirect_pc  input  64  SHALL carry the redirect target address.
REQ-008 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-009 imem_addr  output  64  SHALL be the fetch address, valid while imem_req=1.
REQ-010 imem_ready  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  SHALL indicate read data returned this cycle; response latency is 1 or more cycles.
REQ-012 imem_rdata  input  32  SHALL carry the instruction word.
REQ-013 if_pc  output  64  SHALL be the PC of the held instruction.
REQ-014 if_instruction  output  32  SHALL be the held instruction, or NOP_INSTR.
REQ-015 if_valid  output  1  SHALL indicate that a held instruction is present.
REQ-016 fetch_stall  output  1  SHALL equal !if_valid and be sent to the hazard unit.

Function
REQ-017 The block SHALL keep one outstanding memory request at most and a one-entry output buffer (out_pc, out_instr, out_valid).
REQ-018 The FSM SHALL have three states: REQ, WAIT and DROP.
REQ-019 In REQ, imem_req SHALL be 1 when out_valid=0, or when out_valid=1 and stall_if_id=0; imem_addr SHALL equal pc.
REQ-020 REQ SHALL move to WAIT on imem_req && imem_ready.
REQ-021 In WAIT with imem_rvalid, the block SHALL load out_pc<=pc, out_instr<=imem_rdata, out_valid<=1 and pc<=pc+4, wrapping modulo 2^64, then return to REQ.
REQ-022 When out_valid=1 and stall_if_id=0 at an edge, the buffer SHALL be consumed (out_valid<=0) unless it is refilled at the same edge.
REQ-023 While stall_if_id=1, if_pc, if_instruction and if_valid SHALL hold stable.
REQ-024 redirect_valid SHALL have priority over all other events: pc<=redirect_pc with bits[1:0] forced to 0, and out_valid<=0.
REQ-025 Redirect in REQ without acceptance SHALL stay in REQ, with the next request using the new pc.
REQ-026 Redirect in REQ with acceptance in the same cycle SHALL go to DROP.
REQ-027 Redirect in WAIT without imem_rvalid SHALL go to DROP.
REQ-028 Redirect in WAIT with imem_rvalid in the same cycle SHALL discard the data, leave pc unincremented, and go to REQ.
REQ-029 In DROP, imem_req SHALL be 0; imem_rvalid SHALL be discarded and the FSM SHALL go to REQ.
REQ-030 A redirect in DROP SHALL update pc and keep the FSM in DROP.
REQ-031 imem_rvalid received in REQ SHALL be ignored, as it is a protocol error.
REQ-032 Best-case latency SHALL be: request accepted in cycle N, rvalid in N+1, if_valid=1 in N+2. Sustained throughput SHALL be one instruction per 2 cycles with 1-cycle memory.

Reset
REQ-033 While rst=1, imem_req SHALL be forced to 0.
REQ-034 At a reset edge the block SHALL load state=REQ, pc=RESET_PC, out_valid=0, out_pc=0 and out_instr=NOP_INSTR, giving if_valid=0, fetch_stall=1 and if_instruction=NOP_INSTR.
REQ-035 Reset in WAIT or DROP SHALL abandon the outstanding response; a stale rvalid arriving after reset in REQ SHALL be ignored.

Verification
REQ-036 Reset release with 1-cycle memory returning 0x00500093 at address 0 -> imem_addr=0 in cycle 0; if_valid=1, if_pc=0, if_instruction=0x00500093 in cycle 2; the next request has imem_addr=4.
REQ-037 stall_if_id=1 for 3 cycles while an instruction is held -> outputs stable, imem_req=0 throughout, a request issues in the cycle stall drops, and no instruction is lost or duplicated.
REQ-038 Redirect to 0x100 while in WAIT with rdata delayed 3 cycles -> the returned word is discarded, the next imem_addr=0x100, and if_pc=0x100 is the next valid output.
REQ-039 Redirect and imem_rvalid in the same cycle -> the data is dropped, if_valid=0 the next cycle, and the next imem_addr equals the target.
REQ-040 redirect_pc=0x103 -> imem_addr=0x100.
REQ-041 rst asserted in WAIT, with a stale imem_rvalid one cycle after release -> the stale response is ignored and the first valid if_pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetches 32-bit instructions into a one-entry IF/ID buffer, with one memory request outstanding at most.
// Latency: request accepted in cycle N, response in N+1 or later, if_valid one cycle after the response.
// Backpressure: stall_if_id holds the buffer and blocks new requests while it is full; imem_ready gates acceptance.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if_id,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        fetch_stall
);

  // REQ: may issue a request; WAIT: live response pending; DROP: response pending that must be discarded
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_valid;
  logic [63:0] redirect_target;
  logic        req_fire;

  // Redirect targets are word aligned; the low two bits are ignored
  assign redirect_target = {redirect_pc[63:2], 2'b00};

  // Request only when the buffer is free or is being drained this cycle, so a response always has a home
  always_comb begin
    imem_req = 1'b0;
    if (!rst && (state == ST_REQ) && (!out_valid || !stall_if_id)) begin
      imem_req = 1'b1;
    end
  end

  assign imem_addr      = pc;
  assign req_fire       = imem_req && imem_ready;
  assign if_pc          = out_pc;
  assign if_instruction = out_valid ? out_instr : NOP_INSTR;
  assign if_valid       = out_valid;
  assign fetch_stall    = !out_valid;

  // Fetch FSM, PC and output buffer; redirect overrides every other update
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      out_pc    <= 64'h0;
      out_instr <= NOP_INSTR;
      out_valid <= 1'b0;
    end else begin
      // Downstream takes the held instruction; a refill below overrides this
      if (out_valid && !stall_if_id) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_REQ: begin
          // A response arriving here has no matching request and is ignored
          if (redirect_valid) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
            // If the old-address request was just accepted, its response must be thrown away
            state     <= req_fire ? ST_DROP : ST_REQ;
          end else if (req_fire) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
            // Data landing with the redirect is stale; otherwise it is still to come
            state     <= imem_rvalid ? ST_REQ : ST_DROP;
          end else if (imem_rvalid) begin
            out_pc    <= pc;
            out_instr <= imem_rdata;
            out_valid <= 1'b1;
            pc        <= pc + 64'd4;
            state     <= ST_REQ;
          end
        end

        ST_DROP: begin
          if (redirect_valid) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
          end
          // Leave only once the abandoned response has been swallowed; a same-cycle
          // redirect must not hold us here or nothing would ever release the FSM
          if (imem_rvalid) begin
            state <= ST_REQ;
          end
        end

        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed sequences against a transaction-level model.
// Latency: drives inputs just after the falling edge, samples outputs 1 time unit later.
// Backpressure: the bench memory accepts at most one request and answers after mem_lat cycles.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if_id;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        fetch_stall;

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if_id   (stall_if_id),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .if_instruction(if_instruction),
    .if_valid      (if_valid),
    .fetch_stall   (fetch_stall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory environment: one pending response, answered mem_lat cycles after acceptance
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  bit          mem_pend = 1'b0;
  logic [63:0] mem_addr = 64'h0;
  bit          inject_rv = 1'b0;
  logic        dut_req;
  logic [63:0] dut_addr;

  // Model: outstanding fetch record plus the one-entry output buffer
  bit          m_known = 1'b0;
  bit          m_out   = 1'b0;
  bit          m_live  = 1'b0;
  logic [63:0] m_req_addr = 64'h0;
  logic [63:0] m_pc = 64'h0;
  bit          m_buf_v = 1'b0;
  logic [63:0] m_buf_pc = 64'h0;
  logic [31:0] m_buf_instr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00500093;
    return {a[27:4], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return !rst && !m_out && (!m_buf_v || !stall_if_id);
  endfunction

  task automatic model_update();
    bit req, got, deliver;
    logic [63:0] old_pc;
    if (rst) begin
      m_out       = 1'b0;
      m_live      = 1'b0;
      m_pc        = RESET_PC;
      m_buf_v     = 1'b0;
      m_buf_pc    = 64'h0;
      m_buf_instr = NOP_INSTR;
      m_known     = 1'b1;
    end else begin
      req     = model_req();
      got     = imem_rvalid && m_out;
      deliver = got && m_live && !redirect_valid;
      old_pc  = m_pc;
      if (redirect_valid) begin
        m_buf_v = 1'b0;
      end else if (deliver) begin
        m_buf_v     = 1'b1;
        m_buf_pc    = m_req_addr;
        m_buf_instr = imem_rdata;
      end else if (m_buf_v && !stall_if_id) begin
        m_buf_v = 1'b0;
      end
      if (redirect_valid) m_pc = redirect_pc & ~64'h3;
      else if (deliver)   m_pc = m_req_addr + 64'd4;
      if (got) m_out = 1'b0;
      if (req && imem_ready) begin
        m_out      = 1'b1;
        m_live     = 1'b1;
        m_req_addr = old_pc;
      end
      if (redirect_valid) m_live = 1'b0;
    end
  endtask

  task automatic drive(input logic stl, input logic redir, input logic [63:0] rpc,
                       input logic rdy, input logic rs);
    stall_if_id    = stl;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    rst            = rs;
    imem_rvalid    = inject_rv || (mem_pend && mem_cnt == 0);
    imem_rdata     = inject_rv ? 32'hdeadbeef : mem_word(mem_addr);
    #1;
    dut_req  = imem_req;
    dut_addr = imem_addr;
    if (m_known) begin
      chk("imem_req", 64'(imem_req), 64'(model_req()));
      if (model_req()) chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", 64'(if_valid), 64'(m_buf_v));
      chk("if_pc", if_pc, m_buf_pc);
      chk("if_instruction", 64'(if_instruction), 64'(m_buf_v ? m_buf_instr : NOP_INSTR));
      chk("fetch_stall", 64'(fetch_stall), 64'(!m_buf_v));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (dut_req && imem_ready && !mem_pend) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat - 1;
      mem_addr = dut_addr;
    end
    inject_rv = 1'b0;
    @(negedge clk);
  endtask

  task automatic step(input logic stl, input logic redir, input logic [63:0] rpc,
                      input logic rdy, input logic rs);
    drive(stl, redir, rpc, rdy, rs);
    tick();
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    chk("rst_imem_req", 64'(imem_req), 64'h0);
    chk("rst_if_valid", 64'(if_valid), 64'h0);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'h1);
    chk("rst_if_instruction", 64'(if_instruction), 64'h13);
    tick();

    // First fetch with 1-cycle memory
    drive(0, 0, 0, 1, 0);
    chk("first_req", 64'(imem_req), 64'h1);
    chk("first_addr", imem_addr, 64'h0);
    tick();
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("first_if_valid", 64'(if_valid), 64'h1);
    chk("first_if_pc", if_pc, 64'h0);
    chk("first_if_instr", 64'(if_instruction), 64'h00500093);
    chk("second_addr", imem_addr, 64'h4);
    tick();
    step(0, 0, 0, 1, 0);

    // Stall for 3 cycles while pc 4 is held
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0);
      chk("stall_no_req", 64'(imem_req), 64'h0);
      chk("stall_if_pc", if_pc, 64'h4);
      chk("stall_if_instr", 64'(if_instruction), 64'(mem_word(64'h4)));
      tick();
    end
    drive(0, 0, 0, 1, 0);
    chk("unstall_req", 64'(imem_req), 64'h1);
    chk("unstall_addr", imem_addr, 64'h8);
    chk("unstall_if_pc", if_pc, 64'h4);
    tick();
    step(0, 0, 0, 1, 0);

    // Redirect to 0x100 while waiting on a 3-cycle response
    mem_lat = 3;
    step(0, 0, 0, 1, 0);
    step(0, 1, 64'h100, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("drop_no_req", 64'(imem_req), 64'h0);
    chk("drop_if_valid", 64'(if_valid), 64'h0);
    tick();
    mem_lat = 1;
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("redir_req", 64'(imem_req), 64'h1);
    chk("redir_addr", imem_addr, 64'h100);
    tick();
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("redir_if_valid", 64'(if_valid), 64'h1);
    chk("redir_if_pc", if_pc, 64'h100);
    tick();

    // Redirect coincident with rvalid
    step(0, 1, 64'h200, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("coinc_if_valid", 64'(if_valid), 64'h0);
    chk("coinc_req", 64'(imem_req), 64'h1);
    chk("coinc_addr", imem_addr, 64'h200);
    tick();
    step(0, 0, 0, 1, 0);

    // Unaligned redirect in REQ without acceptance
    step(0, 1, 64'h103, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("align_req", 64'(imem_req), 64'h1);
    chk("align_addr", imem_addr, 64'h100);
    chk("align_if_valid", 64'(if_valid), 64'h0);
    tick();

    // Redirect with acceptance, then a second redirect while dropping
    mem_lat = 2;
    step(0, 1, 64'h43, 1, 0);
    drive(0, 1, 64'h80, 1, 0);
    chk("drop2_no_req", 64'(imem_req), 64'h0);
    tick();
    mem_lat = 1;
    drive(0, 0, 0, 1, 0);
    chk("drop3_no_req", 64'(imem_req), 64'h0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("drop_redir_req", 64'(imem_req), 64'h1);
    chk("drop_redir_addr", imem_addr, 64'h80);
    tick();
    step(0, 0, 0, 1, 0);

    // Spurious rvalid while in REQ with a held instruction
    inject_rv = 1'b1;
    step(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    chk("spur_if_valid", 64'(if_valid), 64'h1);
    chk("spur_if_pc", if_pc, 64'h80);
    chk("spur_if_instr", 64'(if_instruction), 64'(mem_word(64'h80)));
    tick();
    drive(0, 0, 0, 1, 0);
    chk("spur_next_addr", imem_addr, 64'h84);
    tick();
    step(0, 0, 0, 1, 0);

    // PC wrap at the top of the address space
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'h0);
    tick();
    step(0, 0, 0, 1, 0);

    // Reset while waiting; the stale response arrives after release
    mem_lat = 3;
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("rstw_no_req", 64'(imem_req), 64'h0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("rstw_req", 64'(imem_req), 64'h1);
    chk("rstw_addr", imem_addr, RESET_PC);
    chk("rstw_if_valid", 64'(if_valid), 64'h0);
    tick();
    step(0, 0, 0, 0, 0);
    mem_lat = 1;
    drive(0, 0, 0, 0, 0);
    chk("stale_if_valid", 64'(if_valid), 64'h0);
    tick();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("rstw_first_valid", 64'(if_valid), 64'h1);
    chk("rstw_first_pc", if_pc, RESET_PC);
    chk("rstw_first_instr", 64'(if_instruction), 64'h00500093);
    tick();

    // Mixed stalls, ready gaps, latencies and one redirect
    for (int i = 0; i < 30; i++) begin
      mem_lat = 1 + (i % 3);
      step((i % 4 == 1) || (i % 7 == 3), i == 17, 64'h300, i % 5 != 2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
